alu_mc: RTL and testbench



---
 rtl/alu_mc.sv | 202 ++++++++++++++++++++
 tb/tb_alu_mc.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle LEGv8 ALU with iterative MUL/DIV, shifts and NZCV flags
module alu_mc #(
  parameter int N   = 64,
  parameter int SHW = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   ALUControl,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         zero,
  output logic         negative,
  output logic         carry,
  output logic         overflow,
  output logic         illegal
);

  localparam int CW = $clog2(N);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t state, state_nx;

  // Iteration state shared by the multiplier and divider
  logic [CW-1:0] cnt;
  logic [N-1:0]  acc, mcand, mplier;
  logic [N-1:0]  rem, quo, dvsr;
  logic          neg_q, div0;

  // Combinational datapath helpers
  logic          long_op, is_mul, sdiv, last;
  logic [N:0]    sum, dif;
  logic [SHW-1:0] shamt;
  logic [N-1:0]  a_mag, b_mag;
  logic [N-1:0]  mul_sum;
  logic [N:0]    rem_sh;
  logic          div_ge;
  logic [N-1:0]  rem_nx, quo_nx;

  // Final-value load strobe and the values to register
  logic          ld;
  logic [N-1:0]  fin_res;
  logic          fin_c, fin_v, fin_ill;

  assign is_mul  = (ALUControl == 4'b1000);
  assign long_op = is_mul || (ALUControl == 4'b1010) || (ALUControl == 4'b1011);
  assign sdiv    = ALUControl[0];
  assign last    = (cnt == CW'(N - 1));

  assign sum   = {1'b0, a} + {1'b0, b};
  assign dif   = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
  assign shamt = b[SHW-1:0];

  // Divide works on magnitudes; the most-negative value maps onto its unsigned pattern
  assign a_mag = (sdiv && a[N-1]) ? -a : a;
  assign b_mag = (sdiv && b[N-1]) ? -b : b;

  // One shift-add multiplier step
  assign mul_sum = acc + (mplier[0] ? mcand : '0);

  // One restoring-division step: bring in the next dividend bit, subtract if it fits
  assign rem_sh = {rem, quo[N-1]};
  assign div_ge = (rem_sh >= {1'b0, dvsr});
  assign rem_nx = div_ge ? (rem_sh[N-1:0] - dvsr) : rem_sh[N-1:0];
  assign quo_nx = {quo[N-2:0], div_ge};

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (in_valid) begin
        if (is_mul)       state_nx = S_MUL;
        else if (long_op) state_nx = S_DIV;
        else              state_nx = S_DONE;
      end
      S_MUL:  if (last) state_nx = S_DONE;
      S_DIV:  if (last) state_nx = S_FIX;
      S_FIX:  state_nx = S_DONE;
      S_DONE: if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
  end

  // Select the value to register as the result, and when
  always_comb begin
    ld      = 1'b0;
    fin_res = '0;
    fin_c   = 1'b0;
    fin_v   = 1'b0;
    fin_ill = 1'b0;
    case (state)
      S_IDLE: if (in_valid && !long_op) begin
        ld = 1'b1;
        case (ALUControl)
          4'b0000: fin_res = a & b;
          4'b0001: fin_res = a | b;
          4'b0010: begin
            fin_res = sum[N-1:0];
            fin_c   = sum[N];
            fin_v   = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
          end
          4'b0110: begin
            fin_res = dif[N-1:0];
            fin_c   = dif[N];
            fin_v   = (a[N-1] != b[N-1]) && (dif[N-1] != a[N-1]);
          end
          4'b0111: fin_res = b;
          4'b0011: fin_res = a << shamt;
          4'b0100: fin_res = a >> shamt;
          default: fin_ill = 1'b1;
        endcase
      end
      S_MUL: if (last) begin
        ld      = 1'b1;
        fin_res = mul_sum;
      end
      S_FIX: begin
        ld      = 1'b1;
        fin_res = div0 ? '0 : (neg_q ? -quo : quo);
      end
      default: ;
    endcase
  end

  // Iterative multiply/divide registers; operands are captured only at acceptance
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      rem    <= '0;
      quo    <= '0;
      dvsr   <= '0;
      neg_q  <= 1'b0;
      div0   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          cnt    <= '0;
          acc    <= '0;
          mcand  <= a;
          mplier <= b;
          rem    <= '0;
          quo    <= a_mag;
          dvsr   <= b_mag;
          neg_q  <= sdiv && (a[N-1] ^ b[N-1]);
          div0   <= (b == '0);
        end
        S_MUL: begin
          acc    <= mul_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
        end
        S_DIV: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Result and flags registered together; held until the next load
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result   <= '0;
      zero     <= 1'b0;
      negative <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      illegal  <= 1'b0;
    end else if (ld) begin
      result   <= fin_res;
      zero     <= (fin_res == '0);
      negative <= fin_res[N-1];
      carry    <= fin_c;
      overflow <= fin_v;
      illegal  <= fin_ill;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - directed self-checking bench for alu_mc
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic [3:0]  ALUControl = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] result;
  logic        zero, negative, carry, overflow, illegal;

  int checks = 0;
  int failures = 0;
  int lat;
  logic ov_seen;

  alu_mc #(.N(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .ALUControl (ALUControl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .negative   (negative),
    .carry      (carry),
    .overflow   (overflow),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one request, then count cycles until out_valid (latency 1 = valid right after accept)
  task automatic run_op(input logic [63:0] ta, input logic [63:0] tb, input logic [3:0] tc,
                        output int l);
    @(negedge clk);
    chk("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
    a = ta; b = tb; ALUControl = tc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    l = 1;
    while (!out_valid && l < 200) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    // Reset held for three cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_flags", {59'd0, zero, negative, carry, overflow, illegal}, 64'd0);

    // ADD signed overflow
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010, lat);
    chk("add_lat", 64'(lat), 64'd1);
    chk("add_res", result, 64'h8000_0000_0000_0000);
    chk("add_zncvi", {59'd0, zero, negative, carry, overflow, illegal}, 64'b01010);
    release_out();

    // SUB equal operands: zero and not-borrow
    run_op(64'd5, 64'd5, 4'b0110, lat);
    chk("sub_lat", 64'(lat), 64'd1);
    chk("sub_res", result, 64'd0);
    chk("sub_zncvi", {59'd0, zero, negative, carry, overflow, illegal}, 64'b10100);
    release_out();

    // AND / OR / PASS b
    run_op(64'hF0, 64'h3C, 4'b0000, lat);
    chk("and_res", result, 64'h30);
    release_out();
    run_op(64'hF0, 64'h0F, 4'b0001, lat);
    chk("or_res", result, 64'hFF);
    release_out();
    run_op(64'd1, 64'hDEAD_BEEF, 4'b0111, lat);
    chk("pass_res", result, 64'hDEAD_BEEF);
    chk("pass_c", {63'd0, carry}, 64'd0);
    release_out();

    // MUL latency and backpressure
    run_op(64'hFFFF_FFFF, 64'h1_0000_0001, 4'b1000, lat);
    chk("mul_lat", 64'(lat), 64'd65);
    chk("mul_res", result, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("mul_n", {63'd0, negative}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("mul_hold_res", result, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("mul_hold_in_ready", {63'd0, in_ready}, 64'd0);
      chk("mul_hold_out_valid", {63'd0, out_valid}, 64'd1);
    end
    release_out();
    chk("mul_back_idle", {63'd0, in_ready}, 64'd1);

    // SDIV signs
    run_op(-64'sd7, 64'd2, 4'b1011, lat);
    chk("sdiv_lat", 64'(lat), 64'd66);
    chk("sdiv_res", result, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("sdiv_n", {63'd0, negative}, 64'd1);
    release_out();

    // SDIV most-negative by -1 wraps, no overflow
    run_op(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1011, lat);
    chk("sdiv_min_res", result, 64'h8000_0000_0000_0000);
    chk("sdiv_min_v", {63'd0, overflow}, 64'd0);
    release_out();

    // UDIV by zero
    run_op(64'd9, 64'd0, 4'b1010, lat);
    chk("udiv0_lat", 64'(lat), 64'd66);
    chk("udiv0_res", result, 64'd0);
    chk("udiv0_zncvi", {59'd0, zero, negative, carry, overflow, illegal}, 64'b10000);
    release_out();

    // Shifts use only b[5:0]
    run_op(64'd1, 64'hFFFF_FFFF_FFFF_FF43, 4'b0011, lat);
    chk("lsl_res", result, 64'd8);
    release_out();
    run_op(64'h8000_0000_0000_0000, 64'd63, 4'b0100, lat);
    chk("lsr_res", result, 64'd1);
    release_out();
    run_op(64'h1234, 64'd64, 4'b0011, lat);
    chk("lsl0_res", result, 64'h1234);
    release_out();

    // Illegal code
    run_op(64'd3, 64'd4, 4'b1111, lat);
    chk("ill_lat", 64'(lat), 64'd1);
    chk("ill_res", result, 64'd0);
    chk("ill_flag", {63'd0, illegal}, 64'd1);
    chk("ill_zero", {63'd0, zero}, 64'd1);
    release_out();

    // Abort a DIV with reset at cycle 20
    @(negedge clk);
    a = 64'd100; b = 64'd7; ALUControl = 4'b1010; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_async_in_ready", {63'd0, in_ready}, 64'd1);
    chk("abort_async_out_valid", {63'd0, out_valid}, 64'd0);
    chk("abort_async_result", result, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    ov_seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      ov_seen = ov_seen | out_valid;
    end
    chk("abort_no_result", {63'd0, ov_seen}, 64'd0);
    run_op(64'd100, 64'd7, 4'b1010, lat);
    chk("post_abort_lat", 64'(lat), 64'd66);
    chk("post_abort_res", result, 64'd14);
    release_out();

    // Operand isolation during MUL
    @(negedge clk);
    a = 64'd12345; b = 64'd1000; ALUControl = 4'b1000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      ALUControl = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
      lat++;
    end
    chk("iso_lat", 64'(lat), 64'd65);
    chk("iso_res", result, 64'd12345000);
    release_out();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
